// File: rtl/button_event.sv
// button_event: classifies debounced button gestures into press/release edges
// and single-click / double-click / long-press pulses, plus a saturating
// press counter. All outputs are registered; one clock domain.
//
// There is no valid/ready handshake here: db_i is a level, and every output
// pulse is asserted for exactly one clock with no back-pressure.
module button_event #(
  parameter int LONG_CYCLES   = 1000,
  parameter int DCLICK_CYCLES = 300,
  parameter int CNT_W         = 8
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             db_i,
  input  logic             clr_i,
  output logic             held_o,
  output logic             press_o,
  output logic             release_o,
  output logic             long_o,
  output logic             single_o,
  output logic             double_o,
  output logic [CNT_W-1:0] count_o,
  output logic [2:0]       state_o
);

  typedef enum logic [2:0] {
    S_IDLE     = 3'd0,
    S_PRESSED  = 3'd1,
    S_LONG     = 3'd2,
    S_WAIT2    = 3'd3,
    S_PRESSED2 = 3'd4
  } state_t;

  // Timer must reach max(LONG, DCLICK)-1; it saturates at the max so it can
  // idle in any state without wrapping.
  localparam int T_MAX = (LONG_CYCLES > DCLICK_CYCLES) ? LONG_CYCLES : DCLICK_CYCLES;
  localparam int T_W   = $clog2(T_MAX + 1);

  localparam logic [T_W-1:0]   T_SAT       = T_W'(T_MAX);
  localparam logic [T_W-1:0]   LONG_LAST   = T_W'(LONG_CYCLES - 1);
  localparam logic [T_W-1:0]   DCLICK_LAST = T_W'(DCLICK_CYCLES - 1);
  localparam logic [CNT_W-1:0] CNT_MAX     = '1;

  state_t           state;
  state_t           state_n;
  logic [T_W-1:0]   timer;
  logic             db_q;
  logic             rise;
  logic             fall;
  logic             press_n;
  logic             release_n;
  logic             long_n;
  logic             single_n;
  logic             double_n;

  assign rise    = db_i & ~db_q;
  assign fall    = ~db_i & db_q;
  assign held_o  = db_q;
  assign state_o = state;

  // Next-state and next-pulse decode; edges take priority over timer expiry.
  always_comb begin
    state_n   = state;
    press_n   = 1'b0;
    release_n = 1'b0;
    long_n    = 1'b0;
    single_n  = 1'b0;
    double_n  = 1'b0;
    case (state)
      S_IDLE: begin
        if (rise) begin
          state_n = S_PRESSED;
          press_n = 1'b1;
        end
      end
      S_PRESSED: begin
        if (fall) begin
          state_n   = S_WAIT2;
          release_n = 1'b1;
        end else if (db_i && (timer == LONG_LAST)) begin
          state_n = S_LONG;
          long_n  = 1'b1;
        end
      end
      S_LONG: begin
        if (fall) begin
          state_n   = S_IDLE;
          release_n = 1'b1;
        end
      end
      S_WAIT2: begin
        if (rise) begin
          state_n  = S_PRESSED2;
          press_n  = 1'b1;
          double_n = 1'b1;
        end else if (timer == DCLICK_LAST) begin
          state_n  = S_IDLE;
          single_n = 1'b1;
        end
      end
      S_PRESSED2: begin
        if (fall) begin
          state_n   = S_IDLE;
          release_n = 1'b1;
        end
      end
      default: state_n = S_IDLE;
    endcase
  end

  // State, timer, edge-detect register and registered pulse outputs.
  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      state     <= S_IDLE;
      timer     <= '0;
      db_q      <= 1'b0;
      press_o   <= 1'b0;
      release_o <= 1'b0;
      long_o    <= 1'b0;
      single_o  <= 1'b0;
      double_o  <= 1'b0;
    end else begin
      state     <= state_n;
      db_q      <= db_i;
      press_o   <= press_n;
      release_o <= release_n;
      long_o    <= long_n;
      single_o  <= single_n;
      double_o  <= double_n;
      if (state_n != state) begin
        timer <= '0;
      end else if (timer != T_SAT) begin
        timer <= timer + 1'b1;
      end
    end
  end

  // Saturating press counter; clear beats a coincident press.
  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      count_o <= '0;
    end else if (clr_i) begin
      count_o <= '0;
    end else if (press_n && (count_o != CNT_MAX)) begin
      count_o <= count_o + 1'b1;
    end
  end

endmodule

// File: doc/button_event.md
# button_event

Event classifier that sits directly downstream of the debouncer and consumes its debounced switch level. It detects press and release edges and classifies each gesture as single click, double click or long press, each reported as a one-cycle pulse. It also keeps a saturating press counter for status registers and LED demos. All outputs are registered, and the block is fully synchronous to one clock.

## Interface
- `LONG_CYCLES`, default 1000: hold time in clocks that qualifies a long press; must be ≥ 2.
- `DCLICK_CYCLES`, default 300: window in clocks after a short release in which a second press counts as a double click; must be ≥ 2.
- `CNT_W`, default 8: width of the press counter.
- `clk_i`  in  1  system clock; every register is rising-edge.
- `rst_i`  in  1  reset, asynchronous, active-low.
- `db_i`  in  1  debounced switch level from the debouncer; already synchronous to `clk_i`.
- `clr_i`  in  1  synchronous clear of `count_o`.
- `held_o`  out  1  registered copy of `db_i`.
- `press_o`  out  1  one-cycle pulse on each sampled 0→1 of `db_i`.
- `release_o`  out  1  one-cycle pulse on each sampled 1→0 of `db_i`.
- `long_o`  out  1  one-cycle pulse when a press reaches `LONG_CYCLES`.
- `single_o`  out  1  one-cycle pulse confirming a single click when the double-click window expires.
- `double_o`  out  1  one-cycle pulse on the second press of a double click.
- `count_o`  out  `CNT_W`  number of presses, saturating at all-ones.

## Operation
- Edge detect:
  - `db_q` is `db_i` registered; `held_o` = `db_q`.
  - rise = `db_i & ~db_q`; fall = `~db_i & db_q`.
- Timer: up-counter wide enough for max(`LONG_CYCLES`, `DCLICK_CYCLES`). Cleared to 0 on every state transition; increments by 1 each cycle otherwise. Never wraps within a state.
- FSM states: IDLE, PRESSED, LONG, WAIT2, PRESSED2.
  - IDLE: rise → PRESSED, pulse `press_o`.
  - PRESSED:
    - fall → WAIT2, pulse `release_o`.
    - timer = `LONG_CYCLES`−1 with `db_i` high → LONG, pulse `long_o`.
    - Fall and timer expiry in the same cycle: fall wins, no `long_o`.
  - LONG: fall → IDLE, pulse `release_o`. `long_o` fires only once per press.
  - WAIT2:
    - rise → PRESSED2, pulse `press_o` and `double_o` together.
    - timer = `DCLICK_CYCLES`−1 with no rise → IDLE, pulse `single_o`.
    - Rise and expiry in the same cycle: rise wins (double click, no `single_o`).
  - PRESSED2: fall → IDLE, pulse `release_o`. No long-press detection in this state.
- Counter:
  - +1 on every `press_o`; holds at 2^`CNT_W`−1.
  - `clr_i` forces 0 on the next edge; `clr_i` in the same cycle as a press gives 0.
- Exactly one of `long_o`, `single_o` or `double_o` is produced per gesture.

## Timing
- Reset (async, `rst_i` = 0):
  - State IDLE, timer 0, `db_q` 0, `count_o` 0.
  - All pulse outputs and `held_o` go to 0 immediately, without waiting for a clock edge.
  - Asserting reset mid-gesture aborts the gesture; no pulse is emitted.
- After reset release, `db_q` starts at 0. If `db_i` is high at the first edge, that is a rise and produces `press_o`.
- Latency:
  - `press_o` and `release_o` are valid in the cycle after the edge at which the new `db_i` level is first sampled.
  - `held_o` follows `db_i` with the same one-cycle latency.
- `long_o` rises exactly `LONG_CYCLES` cycles after `press_o` rises, provided `db_i` is sampled high at every intervening edge.
- `single_o` rises exactly `DCLICK_CYCLES` cycles after `release_o` rises, provided no rise is sampled in between.
- `double_o` requires the second rise within `DCLICK_CYCLES` cycles of `release_o`, last cycle inclusive.
- `count_o` updates in the same cycle that `press_o` is high.

## Test plan
Bench parameters: `LONG_CYCLES` = 20, `DCLICK_CYCLES` = 10, `CNT_W` = 4.
- Reset hold, then release with `db_i` = 0 → all outputs 0, `count_o` = 0. Then `db_i` = 1 for 5 cycles, then 0 → `press_o` 1 cycle, `release_o` 1 cycle, `single_o` exactly 10 cycles after `release_o`, `count_o` = 1.
- `db_i` high for 30 cycles → `long_o` exactly 20 cycles after `press_o`, once only. `release_o` on the fall, no `single_o`.
- Press 5 cycles, low 10 cycles, press again → `double_o` coincident with the second `press_o`, no `single_o`, `count_o` = 2. Low for 11 cycles instead → `single_o` after 10 cycles, and the later press is a fresh gesture.
- Drop `db_i` at the edge where the long timer expires (press of exactly 20 sampled-high cycles minus one) → `release_o`, no `long_o`. Separately, hit the boundary rise at exactly cycle 10 of WAIT2 → `double_o`, no `single_o`.
- 17 presses with `clr_i` low → `count_o` saturates at 15. Pulse `clr_i` together with a press → `count_o` = 0.
- Assert `rst_i` mid-way through PRESSED → outputs 0 immediately. After release, if `db_i` is still high → new `press_o`, `count_o` = 1.
